// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM control unit for a multicycle RISC-V core with a shared, stallable memory.
//   in : clock, reset (async active-low), op, funct3, funct7b5, Zero, mem_ready
//   out: mem_req, MemWrite, IRWrite, PCWrite, AdrSrc, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
//        ImmSrc, ALUControl, halted, state, retired (retired-instruction count, wraps at 2^32)
module multicycle_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl,
    output logic        halted,
    output logic [3:0]  state,
    output logic [31:0] retired
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10,
        HALT     = 4'd11
    } state_t;

    state_t     cur, nxt;
    logic [1:0] aluop;
    logic       req, mw, irw, pcw, rw;
    logic       retire;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur     <= FETCH;
            retired <= '0;
        end else begin
            cur <= nxt;
            if (retire)
                retired <= retired + 32'd1;
        end
    end

    // Every path back into FETCH completes an instruction; FETCH self-loops
    // (stalls) and HALT never reach FETCH without a reset.
    assign retire = (cur != FETCH) && (nxt == FETCH);

    always_comb begin
        nxt = cur;
        case (cur)
            FETCH:    nxt = mem_ready ? DECODE : FETCH;
            DECODE:   nxt = (op == 7'b0000011 || op == 7'b0100011) ? MEMADR :
                            (op == 7'b0110011) ? EXECR :
                            (op == 7'b0010011) ? EXECI :
                            (op == 7'b1101111) ? JAL :
                            (op == 7'b1100011) ? BEQ : HALT;
            MEMADR:   nxt = (op == 7'b0000011) ? MEMREAD : MEMWRITE;
            MEMREAD:  nxt = mem_ready ? MEMWB : MEMREAD;
            MEMWRITE: nxt = mem_ready ? FETCH : MEMWRITE;
            EXECR, EXECI, JAL: nxt = ALUWB;
            MEMWB, ALUWB, BEQ: nxt = FETCH;
            default:  nxt = HALT;
        endcase
    end

    always_comb begin
        req       = 1'b0;
        mw        = 1'b0;
        irw       = 1'b0;
        pcw       = 1'b0;
        rw        = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        aluop     = 2'b00;
        case (cur)
            FETCH: begin
                req       = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                irw       = mem_ready;
                pcw       = mem_ready;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD: begin
                req    = 1'b1;
                AdrSrc = 1'b1;
            end
            MEMWRITE: begin
                req    = 1'b1;
                AdrSrc = 1'b1;
                mw     = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                rw        = 1'b1;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                aluop   = 2'b10;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                aluop   = 2'b10;
            end
            ALUWB: rw = 1'b1;
            JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                pcw     = 1'b1;
            end
            BEQ: begin
                ALUSrcA = 2'b10;
                aluop   = 2'b01;
                pcw     = Zero;
            end
            default: ;
        endcase
    end

    // The state register resets asynchronously to FETCH, whose Moore outputs
    // request memory; gate the enables so nothing fires while reset is low.
    assign mem_req  = req & reset;
    assign MemWrite = mw & reset;
    assign IRWrite  = irw & reset;
    assign PCWrite  = pcw & reset;
    assign RegWrite = rw & reset;

    // Only R-type (op[5]=1) uses funct7b5 to select subtract; addi ignores it.
    always_comb
        ALUControl = (aluop == 2'b01) ? 3'b001 :
                     (aluop != 2'b10) ? 3'b000 :
                     (funct3 == 3'b000) ? ((op[5] & funct7b5) ? 3'b001 : 3'b000) :
                     (funct3 == 3'b010) ? 3'b101 :
                     (funct3 == 3'b110) ? 3'b011 :
                     (funct3 == 3'b111) ? 3'b010 : 3'b000;

    always_comb
        ImmSrc = (op == 7'b0100011) ? 2'b01 :
                 (op == 7'b1100011) ? 2'b10 :
                 (op == 7'b1101111) ? 2'b11 : 2'b00;

    assign state  = cur;
    assign halted = (cur == HALT);
endmodule
